// File: rtl/led_sequencer.sv
// rtl/led_sequencer.sv - registered N-LED driver with off/static/chase/blink modes and a step-tick prescaler
module led_sequencer #(
  parameter int N_LEDS   = 4,
  parameter int TICK_DIV = 25000000,
  localparam int SEL_W   = $clog2(N_LEDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [1:0]        mode,
  input  logic [SEL_W-1:0]  sel,
  input  logic              dir,
  output logic [N_LEDS-1:0] leds,
  output logic [SEL_W-1:0]  pos,
  output logic              wrap
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [1:0] ST_OFF    = 2'd0;
  localparam logic [1:0] ST_STATIC = 2'd1;
  localparam logic [1:0] ST_CHASE  = 2'd2;
  localparam logic [1:0] ST_BLINK  = 2'd3;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [SEL_W-1:0] POS_LAST = SEL_W'(N_LEDS - 1);
  localparam logic [SEL_W:0]   N_EXT    = (SEL_W + 1)'(N_LEDS);

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_phase;
  logic [SEL_W-1:0]  r_pos;
  logic              r_wrap;
  logic [N_LEDS-1:0] r_leds;

  logic [1:0]        w_state_nxt;
  logic [CNT_W-1:0]  w_cnt_nxt;
  logic              w_phase_nxt;
  logic [SEL_W-1:0]  w_pos_nxt;
  logic              w_wrap_nxt;
  logic [N_LEDS-1:0] w_leds_nxt;
  logic              w_tick;

  assign w_tick = (r_cnt == CNT_LAST);

  // State register: reset clears everything, en=0 freezes every register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_OFF;
      r_cnt   <= '0;
      r_phase <= 1'b1;
      r_pos   <= '0;
      r_wrap  <= 1'b0;
      r_leds  <= '0;
    end else if (en) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_phase <= w_phase_nxt;
      r_pos   <= w_pos_nxt;
      r_wrap  <= w_wrap_nxt;
      r_leds  <= w_leds_nxt;
    end
  end

  // Next-state: a mode change takes priority over any tick, so entry never steps
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_phase_nxt = r_phase;
    w_pos_nxt   = r_pos;
    w_wrap_nxt  = 1'b0;
    if (mode != r_state) begin
      w_state_nxt = mode;
      w_cnt_nxt   = '0;
      w_phase_nxt = 1'b1;
      case (mode)
        ST_OFF:   w_pos_nxt = '0;
        ST_CHASE: w_pos_nxt = ({1'b0, sel} < N_EXT) ? sel : '0;
        default:  w_pos_nxt = sel;
      endcase
    end else begin
      case (r_state)
        ST_OFF: begin
          w_cnt_nxt = '0;
          w_pos_nxt = '0;
        end
        ST_STATIC: begin
          w_cnt_nxt = '0;
          w_pos_nxt = sel;
        end
        ST_CHASE: begin
          if (w_tick) begin
            w_cnt_nxt = '0;
            if (!dir) begin
              if (r_pos == POS_LAST) begin
                w_pos_nxt  = '0;
                w_wrap_nxt = 1'b1;
              end else begin
                w_pos_nxt = r_pos + SEL_W'(1);
              end
            end else begin
              if (r_pos == '0) begin
                w_pos_nxt  = POS_LAST;
                w_wrap_nxt = 1'b1;
              end else begin
                w_pos_nxt = r_pos - SEL_W'(1);
              end
            end
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
        default: begin
          w_pos_nxt = sel;
          if (w_tick) begin
            w_cnt_nxt   = '0;
            w_phase_nxt = ~r_phase;
          end else begin
            w_cnt_nxt = r_cnt + CNT_W'(1);
          end
        end
      endcase
    end
  end

  // Output decode: one-hot of the next position; out-of-range index lights nothing
  always_comb begin
    w_leds_nxt = '0;
    for (int i = 0; i < N_LEDS; i++) begin
      if (w_pos_nxt == SEL_W'(i)) w_leds_nxt[i] = 1'b1;
    end
    if ((w_state_nxt == ST_OFF) || ((w_state_nxt == ST_BLINK) && !w_phase_nxt)) begin
      w_leds_nxt = '0;
    end
  end

  assign leds = r_leds;
  assign pos  = r_pos;
  assign wrap = r_wrap;

endmodule

// File: tb/tb_led_sequencer.sv
// tb/tb_led_sequencer.sv - self-checking bench for led_sequencer against a behavioural model
module tb_led_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_a = 1'b1, en_a = 1'b0, dir_a = 1'b0;
  logic [1:0] mode_a = 2'd0;
  logic [1:0] sel_a = 2'd0;
  logic [3:0] leds_a;
  logic [1:0] pos_a;
  logic       wrap_a;

  logic       rst_b = 1'b1, en_b = 1'b0, dir_b = 1'b0;
  logic [1:0] mode_b = 2'd0;
  logic [2:0] sel_b = 3'd0;
  logic [4:0] leds_b;
  logic [2:0] pos_b;
  logic       wrap_b;

  int total = 0;
  int bad   = 0;

  led_sequencer #(.N_LEDS(4), .TICK_DIV(3)) u_a (
    .clk(clk), .rst(rst_a), .en(en_a), .mode(mode_a), .sel(sel_a), .dir(dir_a),
    .leds(leds_a), .pos(pos_a), .wrap(wrap_a));

  led_sequencer #(.N_LEDS(5), .TICK_DIV(1)) u_b (
    .clk(clk), .rst(rst_b), .en(en_b), .mode(mode_b), .sel(sel_b), .dir(dir_b),
    .leds(leds_b), .pos(pos_b), .wrap(wrap_b));

  // mode: 0 off, 1 static, 2 chase, 3 blink; age counts enabled cycles since the last step tick
  typedef struct {
    int mode;
    int age;
    int lit;
    int pos;
    int wrap;
  } model_t;

  model_t ma, mb;

  function automatic model_t model_next(model_t m, int n, int td, bit rst, bit en,
                                        int mode, int sel, bit dir);
    model_t r = m;
    if (rst) begin
      r.mode = 0; r.age = 0; r.lit = 1; r.pos = 0; r.wrap = 0;
      return r;
    end
    if (!en) return r;
    r.wrap = 0;
    if (mode != m.mode) begin
      r.mode = mode; r.age = 0; r.lit = 1;
      r.pos  = (mode == 0 || (mode == 2 && sel >= n)) ? 0 : sel;
      return r;
    end
    if (mode == 0) r.pos = 0;
    if (mode == 1 || mode == 3) r.pos = sel;
    if (mode >= 2) begin
      if (m.age + 1 == td) begin
        r.age = 0;
        if (mode == 3) begin
          r.lit = 1 - m.lit;
        end else if (!dir) begin
          r.pos  = (m.pos + 1) % n;
          r.wrap = (r.pos == 0) ? 1 : 0;
        end else begin
          r.pos  = (m.pos + n - 1) % n;
          r.wrap = (r.pos == n - 1) ? 1 : 0;
        end
      end else begin
        r.age = m.age + 1;
      end
    end
    return r;
  endfunction

  function automatic int model_leds(model_t m, int n);
    if (m.mode == 0 || (m.mode == 3 && m.lit == 0) || m.pos >= n) return 0;
    return 1 << m.pos;
  endfunction

  function automatic logic [6:0] exp_a();
    return {4'(model_leds(ma, 4)), 2'(ma.pos), 1'(ma.wrap)};
  endfunction

  function automatic logic [8:0] exp_b();
    return {5'(model_leds(mb, 5)), 3'(mb.pos), 1'(mb.wrap)};
  endfunction

  task automatic cycle();
    @(posedge clk);
    ma = model_next(ma, 4, 3, rst_a, en_a, mode_a, sel_a, dir_a);
    mb = model_next(mb, 5, 1, rst_b, en_b, mode_b, sel_b, dir_b);
    #1;
  endtask

  task automatic test_reset();
    en_a = 1'b1; mode_a = 2'd2; sel_a = 2'd0; rst_a = 1'b1;
    en_b = 1'b1; mode_b = 2'd0; sel_b = 3'd0; rst_b = 1'b1;
    repeat (2) cycle();
    total++;
    if ({leds_a, pos_a, wrap_a} !== 7'b0000_00_0) begin
      bad++; $display("FAIL reset_state: got=%b want=%b", {leds_a, pos_a, wrap_a}, 7'b0000_00_0);
    end
    total++;
    if ({leds_a, pos_a, wrap_a} !== exp_a()) begin
      bad++; $display("FAIL reset_model: got=%b want=%b", {leds_a, pos_a, wrap_a}, exp_a());
    end
    rst_a = 1'b0;
    cycle();
    total++;
    if (leds_a !== 4'b0001) begin
      bad++; $display("FAIL reset_release_leds: got=%b want=%b", leds_a, 4'b0001);
    end
  endtask

  task automatic test_static();
    mode_a = 2'd1; sel_a = 2'd0;
    cycle();
    for (int s = 0; s < 4; s++) begin
      sel_a = 2'(s);
      cycle();
      total++;
      if ({leds_a, pos_a} !== {4'(1 << s), 2'(s)}) begin
        bad++; $display("FAIL static_sel%0d: got=%b want=%b", s, {leds_a, pos_a}, {4'(1 << s), 2'(s)});
      end
    end
    repeat (10) begin
      sel_a = 2'($urandom_range(0, 3));
      cycle();
      total++;
      if ({leds_a, pos_a, wrap_a} !== exp_a()) begin
        bad++; $display("FAIL static_random: got=%b want=%b", {leds_a, pos_a, wrap_a}, exp_a());
      end
    end
  endtask

  task automatic test_chase();
    mode_a = 2'd2; sel_a = 2'd2; dir_a = 1'b0;
    cycle();
    total++;
    if ({leds_a, pos_a, wrap_a} !== 7'b0100_10_0) begin
      bad++; $display("FAIL chase_entry: got=%b want=%b", {leds_a, pos_a, wrap_a}, 7'b0100_10_0);
    end
    sel_a = 2'd1;
    for (int k = 1; k <= 9; k++) begin
      if (k == 8) dir_a = 1'b1;
      cycle();
      total++;
      if ({leds_a, pos_a, wrap_a} !== exp_a()) begin
        bad++; $display("FAIL chase_model_k%0d: got=%b want=%b", k, {leds_a, pos_a, wrap_a}, exp_a());
      end
      if (k == 3) begin
        total++;
        if ({pos_a, wrap_a} !== 3'b11_0) begin
          bad++; $display("FAIL chase_step_3: got=%b want=%b", {pos_a, wrap_a}, 3'b11_0);
        end
      end
      if (k == 6) begin
        total++;
        if ({leds_a, pos_a, wrap_a} !== 7'b0001_00_1) begin
          bad++; $display("FAIL chase_wrap_up: got=%b want=%b", {leds_a, pos_a, wrap_a}, 7'b0001_00_1);
        end
      end
      if (k == 7) begin
        total++;
        if (wrap_a !== 1'b0) begin
          bad++; $display("FAIL chase_wrap_pulse_len: got=%b want=0", wrap_a);
        end
      end
      if (k == 9) begin
        total++;
        if ({leds_a, pos_a, wrap_a} !== 7'b1000_11_1) begin
          bad++; $display("FAIL chase_wrap_down: got=%b want=%b", {leds_a, pos_a, wrap_a}, 7'b1000_11_1);
        end
      end
    end
    repeat (24) begin
      dir_a = 1'($urandom_range(0, 1));
      sel_a = 2'($urandom_range(0, 3));
      cycle();
      total++;
      if ({leds_a, pos_a, wrap_a} !== exp_a() || $countones(leds_a) > 1) begin
        bad++; $display("FAIL chase_random: got=%b want=%b", {leds_a, pos_a, wrap_a}, exp_a());
      end
    end
  endtask

  task automatic test_blink();
    logic [3:0] seq [0:4];
    seq[0] = 4'b0010; seq[1] = 4'b0010; seq[2] = 4'b0010; seq[3] = 4'b0000; seq[4] = 4'b0000;
    mode_a = 2'd3; sel_a = 2'd1;
    for (int k = 0; k < 5; k++) begin
      cycle();
      total++;
      if (leds_a !== seq[k]) begin
        bad++; $display("FAIL blink_seq%0d: got=%b want=%b", k, leds_a, seq[k]);
      end
    end
    en_a = 1'b0;
    repeat (5) begin
      cycle();
      total++;
      if (leds_a !== 4'b0000 || {leds_a, pos_a, wrap_a} !== exp_a()) begin
        bad++; $display("FAIL blink_frozen: got=%b want=%b", {leds_a, pos_a, wrap_a}, exp_a());
      end
    end
    en_a = 1'b1;
    cycle();
    total++;
    if (leds_a !== 4'b0000) begin
      bad++; $display("FAIL blink_resume_hold: got=%b want=0000", leds_a);
    end
    cycle();
    total++;
    if (leds_a !== 4'b0010) begin
      bad++; $display("FAIL blink_resume_on: got=%b want=0010", leds_a);
    end
  endtask

  task automatic test_mode_on_tick();
    mode_a = 2'd2; sel_a = 2'd0; dir_a = 1'b0;
    repeat (3) cycle();
    mode_a = 2'd1; sel_a = 2'd3;
    cycle();
    total++;
    if ({leds_a, pos_a, wrap_a} !== 7'b1000_11_0) begin
      bad++; $display("FAIL mode_change_on_tick: got=%b want=%b", {leds_a, pos_a, wrap_a}, 7'b1000_11_0);
    end
    mode_a = 2'd2;
    repeat (3) cycle();
    rst_a = 1'b1;
    cycle();
    total++;
    if ({leds_a, pos_a, wrap_a} !== 7'b0000_00_0 || {leds_a, pos_a, wrap_a} !== exp_a()) begin
      bad++; $display("FAIL reset_mid_chase: got=%b want=%b", {leds_a, pos_a, wrap_a}, 7'b0000_00_0);
    end
    rst_a = 1'b0;
  endtask

  task automatic test_n5_tick1();
    rst_b = 1'b0; mode_b = 2'd1; sel_b = 3'd7;
    repeat (2) begin
      cycle();
      total++;
      if (leds_b !== 5'b00000) begin
        bad++; $display("FAIL n5_static_out_of_range: got=%b want=00000", leds_b);
      end
    end
    mode_b = 2'd2; sel_b = 3'd6; dir_b = 1'b0;
    cycle();
    total++;
    if ({leds_b, pos_b, wrap_b} !== 9'b00001_000_0) begin
      bad++; $display("FAIL n5_chase_entry: got=%b want=%b", {leds_b, pos_b, wrap_b}, 9'b00001_000_0);
    end
    for (int k = 1; k <= 6; k++) begin
      cycle();
      total++;
      if ({pos_b, wrap_b} !== {3'(k % 5), (k == 5)} || {leds_b, pos_b, wrap_b} !== exp_b()) begin
        bad++; $display("FAIL n5_chase_k%0d: got=%b want=%b", k, {leds_b, pos_b, wrap_b}, exp_b());
      end
    end
  endtask

  task automatic test_random();
    repeat (300) begin
      rst_a = ($urandom_range(0, 63) == 0);
      en_a  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) mode_a = 2'($urandom_range(0, 3));
      sel_a = 2'($urandom_range(0, 3));
      dir_a = 1'($urandom_range(0, 1));
      rst_b = ($urandom_range(0, 63) == 0);
      en_b  = ($urandom_range(0, 4) != 0);
      if ($urandom_range(0, 7) == 0) mode_b = 2'($urandom_range(0, 3));
      sel_b = 3'($urandom_range(0, 7));
      dir_b = 1'($urandom_range(0, 1));
      cycle();
      total++;
      if ({leds_a, pos_a, wrap_a} !== exp_a() || $countones(leds_a) > 1) begin
        bad++; $display("FAIL random_a: got=%b want=%b", {leds_a, pos_a, wrap_a}, exp_a());
      end
      total++;
      if ({leds_b, pos_b, wrap_b} !== exp_b() || $countones(leds_b) > 1) begin
        bad++; $display("FAIL random_b: got=%b want=%b", {leds_b, pos_b, wrap_b}, exp_b());
      end
    end
  endtask

  initial begin
    ma = '{mode: 0, age: 0, lit: 1, pos: 0, wrap: 0};
    mb = '{mode: 0, age: 0, lit: 1, pos: 0, wrap: 0};
    test_reset();
    test_static();
    test_chase();
    test_blink();
    test_mode_on_tick();
    test_n5_tick1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
